miner_nonce_dispatch: RTL and testbench

Nonce dispatcher driving one miner core. Given a start/end nonce range and a 256-bit target, it presents each nonce to the core and issues a one-cycle `hash_enable` launch. It then waits for the core's one-cycle `finished` pulse, captures the digest, and compares it against the target. It stops on the first winning nonce or when the range is exhausted, and sits between the top-level job registers and the miner core.

---
 rtl/miner_nonce_dispatch_if.sv | 27 ++
 rtl/miner_nonce_dispatch.sv | 174 +++++++++++++++++
 tb/tb_miner_nonce_dispatch.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/miner_nonce_dispatch_if.sv
// Core-side bus of the nonce dispatcher: launch strobe and nonce toward the
// miner core, digest and completion pulse back from it.
//
// Handshake: hash_enable is a one-cycle launch strobe qualified by nonce.
// finished is a one-cycle completion pulse, and hash_result is valid only
// in that cycle. There is no back-pressure. The master (dispatcher) never
// raises hash_enable while a hash is outstanding, except after an abort.
interface miner_nonce_dispatch_if;
  logic         hash_enable;
  logic [31:0]  nonce;
  logic [255:0] hash_result;
  logic         finished;

  modport master (
    output hash_enable,
    output nonce,
    input  hash_result,
    input  finished
  );

  modport slave (
    input  hash_enable,
    input  nonce,
    output hash_result,
    output finished
  );
endinterface

// File: rtl/miner_nonce_dispatch.sv
// Nonce dispatcher for a single miner core. It walks an inclusive nonce range,
// which may wrap through 0xFFFFFFFF. It launches the core once per nonce and
// compares each digest against a latched 256-bit target. It stops on the
// first win or when the range is exhausted.
// Optional watchdog: define MINER_WATCHDOG_EN to enable the launch-to-finished
// timeout, which drives the FAULT state.
module miner_nonce_dispatch #(
  parameter int TIMEOUT_CYCLES = 511
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [31:0]                   nonce_start,
  input  logic [31:0]                   nonce_end,
  input  logic [255:0]                  target,
  miner_nonce_dispatch_if.master        core,
  output logic                          busy,
  output logic                          found,
  output logic [31:0]                   found_nonce,
  output logic                          exhausted,
  output logic                          fault,
  output logic [2:0]                    dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT      = 3'd2,
    S_CHECK     = 3'd3,
    S_FOUND     = 3'd4,
    S_EXHAUSTED = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  // The watchdog counter is 10 bits wide, so the limit must fit.
  if (TIMEOUT_CYCLES < 400 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 400..1023");
  end

  state_t         state_q, state_d;
  logic [31:0]    nonce_q, nonce_d;
  logic [31:0]    end_q, end_d;
  logic [255:0]   target_q, target_d;
  logic [255:0]   digest_q, digest_d;
  logic           found_q, found_d;
  logic [31:0]    found_nonce_q, found_nonce_d;
  logic           exhausted_q, exhausted_d;
  logic           fault_q, fault_d;
`ifdef MINER_WATCHDOG_EN
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0]     wd_cnt_q, wd_cnt_d;
`endif

  // Next-state and register-update logic. Abort overrides everything.
  always_comb begin
    state_d       = state_q;
    nonce_d       = nonce_q;
    end_d         = end_q;
    target_d      = target_q;
    digest_d      = digest_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    exhausted_d   = exhausted_q;
    fault_d       = fault_q;
`ifdef MINER_WATCHDOG_EN
    wd_cnt_d      = wd_cnt_q;
`endif
    if (abort) begin
      state_d     = S_IDLE;
      found_d     = 1'b0;
      exhausted_d = 1'b0;
      fault_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED, S_FAULT: begin
          if (start) begin
            nonce_d     = nonce_start;
            end_d       = nonce_end;
            target_d    = target;
            found_d     = 1'b0;
            exhausted_d = 1'b0;
            fault_d     = 1'b0;
            state_d     = S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // A finished pulse here belongs to no launch of ours and is ignored.
          state_d = S_WAIT;
`ifdef MINER_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
        end
        S_WAIT: begin
          if (core.finished) begin
            digest_d = core.hash_result;
            state_d  = S_CHECK;
          end
`ifdef MINER_WATCHDOG_EN
          else if (wd_cnt_q == WD_LAST) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            wd_cnt_d = wd_cnt_q + 10'd1;
          end
`endif
        end
        S_CHECK: begin
          if (digest_q < target_q) begin
            found_nonce_d = nonce_q;
            found_d       = 1'b1;
            state_d       = S_FOUND;
          end else if (nonce_q == end_q) begin
            exhausted_d = 1'b1;
            state_d     = S_EXHAUSTED;
          end else begin
            // The add wraps mod 2^32, so ranges with end < start pass through 0.
            nonce_d = nonce_q + 32'd1;
            state_d = S_LAUNCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      nonce_q       <= '0;
      end_q         <= '0;
      target_q      <= '0;
      digest_q      <= '0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      exhausted_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      nonce_q       <= nonce_d;
      end_q         <= end_d;
      target_q      <= target_d;
      digest_q      <= digest_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      exhausted_q   <= exhausted_d;
      fault_q       <= fault_d;
    end
  end

`ifdef MINER_WATCHDOG_EN
  // Watchdog counter of WAIT cycles since the last launch.
  always_ff @(posedge clk) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // hash_enable decodes the single-cycle LAUNCH state, so it can never be
  // high on two consecutive cycles.
  assign core.hash_enable = (state_q == S_LAUNCH);
  assign core.nonce       = nonce_q;
  assign busy             = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                            (state_q == S_CHECK);
  assign found            = found_q;
  assign found_nonce      = found_nonce_q;
  assign exhausted        = exhausted_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_miner_nonce_dispatch.sv
// Bench for miner_nonce_dispatch (default build, watchdog disabled).
module tb_miner_nonce_dispatch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, abort;
  logic [31:0]  nonce_start, nonce_end;
  logic [255:0] target;
  logic         busy, found, exhausted, fault;
  logic [31:0]  found_nonce;
  logic [2:0]   dbg_state;

  miner_nonce_dispatch_if core_if();

  miner_nonce_dispatch #(.TIMEOUT_CYCLES(511)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .nonce_start (nonce_start),
    .nonce_end   (nonce_end),
    .target      (target),
    .core        (core_if),
    .busy        (busy),
    .found       (found),
    .found_nonce (found_nonce),
    .exhausted   (exhausted),
    .fault       (fault),
    .dbg_state_o (dbg_state)
  );

  localparam logic [255:0] P240 = 256'd1 << 240;
  localparam logic [255:0] P250 = 256'd1 << 250;
  localparam logic [255:0] P200 = 256'd1 << 200;
  localparam logic [2:0]   ST_IDLE = 3'd0;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];   // expected launch nonces, in order
  logic [33:0] res_q[$];   // expected {found, exhausted, found_nonce}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- bench core model ----------------
  int          core_delay = 10;
  logic        win_en     = 1'b0;
  logic [31:0] win_nonce  = '0;
  logic [255:0] dig_win   = P200;
  logic [255:0] dig_lose  = P250;

  initial begin
    logic [31:0] n;
    core_if.finished    = 1'b0;
    core_if.hash_result = '0;
    forever begin
      @(negedge clk);
      if (core_if.hash_enable === 1'b1) begin
        n = core_if.nonce;
        repeat (core_delay) @(posedge clk);
        #1;
        core_if.finished    = 1'b1;
        core_if.hash_result = (win_en && n == win_nonce) ? dig_win : dig_lose;
        @(posedge clk);
        #1;
        core_if.finished    = 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  logic prev_he = 1'b0;
  always @(negedge clk) begin
    if (core_if.hash_enable === 1'b1) begin
      check("no_back_to_back_enable", {63'd0, prev_he}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_launch", {32'd0, core_if.nonce}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("launch_nonce", {32'd0, core_if.nonce}, {32'd0, exp_q.pop_front()});
      end
    end
    prev_he = (core_if.hash_enable === 1'b1);
  end

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    logic done;
    logic [33:0] e;
    done = (found === 1'b1) || (exhausted === 1'b1) || (fault === 1'b1);
    if (done && !prev_done) begin
      if (res_q.size() == 0) begin
        check("unexpected_result", {62'd0, found, exhausted}, 64'd0);
      end else begin
        e = res_q.pop_front();
        check("result_flags", {61'd0, fault, found, exhausted}, {62'd0, e[33:32]});
        if (e[33]) check("found_nonce", {32'd0, found_nonce}, {32'd0, e[31:0]});
      end
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t);
    @(posedge clk); #1;
    nonce_start = s; nonce_end = e; target = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (found === 1'b1 || exhausted === 1'b1 || fault === 1'b1) break;
    end
    check(name, {63'd0, (i < budget)}, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    nonce_start = 32'h0; nonce_end = 32'h0; target = '0;

    // Reset held two cycles with start high.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_hash_enable", {63'd0, core_if.hash_enable}, 64'd0);
      check("rst_flags", {60'd0, busy, found, exhausted, fault}, 64'd0);
      check("rst_found_nonce", {32'd0, found_nonce}, 64'd0);
      check("rst_nonce", {32'd0, core_if.nonce}, 64'd0);
      check("rst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;

    // Win on third nonce, finished 340 cycles after each launch.
    core_delay = 340; win_en = 1'b1; win_nonce = 32'h102;
    dig_win = P200; dig_lose = P250;
    exp_q.push_back(32'h100); exp_q.push_back(32'h101); exp_q.push_back(32'h102);
    res_q.push_back({2'b10, 32'h102});
    @(posedge clk); #1;
    nonce_start = 32'h100; nonce_end = 32'h1FF; target = P240; start = 1'b1;
    @(negedge clk);
    check("pre_launch_enable", {63'd0, core_if.hash_enable}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("launch_latency_enable", {63'd0, core_if.hash_enable}, 64'd1);
    check("launch_nonce_direct", {32'd0, core_if.nonce}, 64'h100);
    check("launch_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("enable_one_cycle", {63'd0, core_if.hash_enable}, 64'd0);
    wait_done(1500, "win_timeout");
    check("win_launch_count", exp_q.size(), 64'd0);
    check("win_busy", {63'd0, busy}, 64'd0);

    // Exhaust with wrap, started from FOUND; a start while busy is ignored.
    core_delay = 10; win_en = 1'b0;
    exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0001);
    res_q.push_back({2'b01, 32'h0});
    pulse_start(32'hFFFF_FFFE, 32'h0000_0001, P240);
    @(negedge clk);
    check("start_clears_found", {63'd0, found}, 64'd0);
    repeat (3) @(posedge clk); #1;
    nonce_start = 32'h1234_5678; nonce_end = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200, "exhaust_timeout");
    check("exhaust_launch_count", exp_q.size(), 64'd0);

    // Abort 100 cycles into WAIT; the late winning finished is ignored.
    core_delay = 340; win_en = 1'b1; win_nonce = 32'h20;
    exp_q.push_back(32'h20);
    pulse_start(32'h20, 32'h30, P240);
    repeat (100) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    check("abort_clears_exhausted", {63'd0, exhausted}, 64'd0);
    repeat (300) @(negedge clk);
    check("abort_found", {63'd0, found}, 64'd0);
    check("abort_state_late", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    check("abort_launch_count", exp_q.size(), 64'd0);

    // start and abort together from IDLE: stays IDLE.
    @(posedge clk); #1;
    nonce_start = 32'h40; nonce_end = 32'h40; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    check("start_abort_busy", {63'd0, busy}, 64'd0);

    // Winning finished in the same cycle as abort: digest discarded.
    core_delay = 20; win_en = 1'b1; win_nonce = 32'h50;
    exp_q.push_back(32'h50);
    pulse_start(32'h50, 32'h60, P240);
    repeat (20) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (10) @(negedge clk);
    check("fin_abort_found", {63'd0, found}, 64'd0);
    check("fin_abort_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    check("fin_abort_launch_count", exp_q.size(), 64'd0);

    // Single nonce (start == end), digest equal to target is not a win.
    core_delay = 5; win_en = 1'b0; dig_lose = P240;
    exp_q.push_back(32'h55);
    res_q.push_back({2'b01, 32'h0});
    pulse_start(32'h55, 32'h55, P240);
    wait_done(100, "single_timeout");
    repeat (5) @(negedge clk);
    check("single_launch_count", exp_q.size(), 64'd0);
    check("single_found", {63'd0, found}, 64'd0);
    check("fault_tied_low", {63'd0, fault}, 64'd0);
    check("result_queue_empty", res_q.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
